mux_2: RTL and testbench
========================

# mux_2

Parameterised 2:1 data selector with a combinational output and a registered copy of that output. Control datapaths use it wherever one of two equal-width operands is steered onto a shared bus. The combinational path carries no clock dependency. The registered path and the optional select-activity counter run in the single block clock domain.

## Interface
Parameters:
- WIDTH, 4, data width of d0, d1, y, y_q.
- CNT_W, 8, width of the select-transition counter (only used when MUX_2_SWITCH_CNT_EN is defined).

Ports:
- clk  input  1  block clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- d0  input  WIDTH  data input selected when s = 0.
- d1  input  WIDTH  data input selected when s = 1.
- s  input  1  select.
- y  output  WIDTH  combinational selected data.
- y_q  output  WIDTH  y registered on clk.
- sel_cnt  output  CNT_W  saturating count of s transitions; present only with MUX_2_SWITCH_CNT_EN.

## Operation
- y = d1 when s = 1, else d0.
  - Pure combinational path; no dependency on clk or rst_n.
  - Valid during and after reset.
- Select non-binary handling: s = X or Z must not be resolved to either input. In simulation, y is X for every bit where d0 and d1 differ, and takes the common value where they agree. Synthesis treats s as binary.
- y_q captures y on every rising clk edge. There is no enable.
- s_prev is an internal register holding s sampled at the previous rising edge.
- sel_cnt increments by 1 on each rising edge where s ≠ s_prev.
  - Saturates at 2^CNT_W − 1.
  - No wrap-around.
- Widths: all data paths are exactly WIDTH bits; no extension or truncation. WIDTH ≥ 1. CNT_W ≥ 1.

## Timing
- y latency: 0 cycles. Output settles within combinational delay of any d0, d1 or s change.
- y_q latency: 1 cycle. y_q at edge n+1 equals y just before edge n+1.
- Reset values while rst_n = 0, asserted asynchronously:
  - y_q = 0
  - s_prev = 0
  - sel_cnt = 0
- Reset release: the first rising edge after rst_n goes high loads y_q normally. s_prev also loads, so a leading s = 1 after reset counts as one transition.
- Reset mid-operation: registered state clears immediately, regardless of clk; y keeps following inputs.
- Simultaneous s and data change: y reflects the new s with the new data; there is no glitch-free guarantee.

## Configuration
- MUX_2_SWITCH_CNT_EN
  - Defined: s_prev, sel_cnt register and port are built as described above.
  - Undefined: sel_cnt port, s_prev and counter logic are absent; y and y_q behaviour is unchanged.

## Test plan
Scenarios use WIDTH = 4, vectors applied on the rising edge and checked 1 ns later.
- d0=0101, d1=1010, s=0 -> y=0101; next edge y_q=0101.
- d0=0101, d1=1010, s=1 -> y=1010; next edge y_q=1010.
- d0=1111, d1=0000, toggle s 0→1→0 -> y=1111, 0000, 1111 immediately at each step; with MUX_2_SWITCH_CNT_EN, sel_cnt=2.
- rst_n pulled low between edges with y_q=1010 -> y_q=0 and sel_cnt=0 at once; y still tracks inputs (d0=0011, s=0 -> y=0011).
- s toggled every cycle for 300 cycles with CNT_W=8 -> sel_cnt stops at 255 and holds.
- s=X with d0=1100, d1=1010 -> y=1XX0.

Source files
------------

// File: rtl/mux_2.sv
// ============================================================================
// Module   : mux_2
// Purpose  : WIDTH-bit 2:1 selector with a combinational output (y) and a
//            registered copy (y_q). Define MUX_2_SWITCH_CNT_EN to add a
//            saturating counter of select transitions (sel_cnt).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_2 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
`ifdef MUX_2_SWITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] sel_cnt
`endif
);

    generate
        if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
            $error("mux_2: WIDTH and CNT_W must both be at least 1");
        end
    endgenerate

    // The conditional operator merges d0/d1 bitwise when s is X/Z, so
    // simulation shows X only where the inputs disagree.
    assign y = s ? d1 : d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y;
        end
    end

`ifdef MUX_2_SWITCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s_prev;
    logic sel_toggled;

    assign sel_toggled = (s != s_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev  <= 1'b0;
            sel_cnt <= '0;
        end else begin
            s_prev <= s;
            if (sel_toggled && (sel_cnt != CNT_MAX)) begin
                sel_cnt <= sel_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_2.sv
// ============================================================================
// Module   : tb_mux_2
// Purpose  : Directed self-checking bench for mux_2 (WIDTH=4, CNT_W=8);
//            counter checks are built when MUX_2_SWITCH_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_2;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
`ifdef MUX_2_SWITCH_CNT_EN
    logic [CNT_W-1:0] sel_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    mux_2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d0      (d0),
        .d1      (d1),
        .s       (s),
        .y       (y),
        .y_q     (y_q)
`ifdef MUX_2_SWITCH_CNT_EN
        ,
        .sel_cnt (sel_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // Asynchronous reset pulse placed between clock edges; no checks inside.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d0    = 4'b0101;
        d1    = 4'b1010;
        s     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== 4'b0000) $display("FAIL reset_y_q: got %b, required 0000", y_q);
        else pass_cnt++;
        total_cnt++;
        if (y !== 4'b0101) $display("FAIL reset_y_follows: got %b, required 0101", y);
        else pass_cnt++;
`ifdef MUX_2_SWITCH_CNT_EN
        total_cnt++;
        if (sel_cnt !== 8'd0) $display("FAIL reset_sel_cnt: got %0d, required 0", sel_cnt);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_select_0();
        @(posedge clk);
        d0 = 4'b0101; d1 = 4'b1010; s = 1'b0;
        #1;
        total_cnt++;
        if (y !== 4'b0101) $display("FAIL sel0_y: got %b, required 0101", y);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== 4'b0101) $display("FAIL sel0_y_q: got %b, required 0101", y_q);
        else pass_cnt++;
    endtask

    task automatic test_select_1();
        @(posedge clk);
        d0 = 4'b0101; d1 = 4'b1010; s = 1'b1;
        #1;
        total_cnt++;
        if (y !== 4'b1010) $display("FAIL sel1_y: got %b, required 1010", y);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== 4'b1010) $display("FAIL sel1_y_q: got %b, required 1010", y_q);
        else pass_cnt++;
    endtask

    task automatic test_toggle();
        s = 1'b0;
        pulse_reset();
        @(posedge clk);
        d0 = 4'b1111; d1 = 4'b0000; s = 1'b0;
        #1;
        total_cnt++;
        if (y !== 4'b1111) $display("FAIL toggle_y_s0: got %b, required 1111", y);
        else pass_cnt++;
        @(posedge clk);
        s = 1'b1;
        #1;
        total_cnt++;
        if (y !== 4'b0000) $display("FAIL toggle_y_s1: got %b, required 0000", y);
        else pass_cnt++;
        @(posedge clk);
        s = 1'b0;
        #1;
        total_cnt++;
        if (y !== 4'b1111) $display("FAIL toggle_y_s0_again: got %b, required 1111", y);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== 4'b1111) $display("FAIL toggle_y_q: got %b, required 1111", y_q);
        else pass_cnt++;
`ifdef MUX_2_SWITCH_CNT_EN
        total_cnt++;
        if (sel_cnt !== 8'd2) $display("FAIL toggle_sel_cnt: got %0d, required 2", sel_cnt);
        else pass_cnt++;
`endif
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        d0 = 4'b0101; d1 = 4'b1010; s = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== 4'b1010) $display("FAIL arst_pre_y_q: got %b, required 1010", y_q);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (y_q !== 4'b0000) $display("FAIL arst_y_q: got %b, required 0000", y_q);
        else pass_cnt++;
`ifdef MUX_2_SWITCH_CNT_EN
        total_cnt++;
        if (sel_cnt !== 8'd0) $display("FAIL arst_sel_cnt: got %0d, required 0", sel_cnt);
        else pass_cnt++;
`endif
        d0 = 4'b0011; s = 1'b0;
        #1;
        total_cnt++;
        if (y !== 4'b0011) $display("FAIL arst_y_tracks: got %b, required 0011", y);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== 4'b0011) $display("FAIL arst_release_y_q: got %b, required 0011", y_q);
        else pass_cnt++;
    endtask

    // After edge n of the loop, n-1 transitions have been seen (edge 1 sees
    // s=0 against the reset value), so the count is min(n-1, 255).
    task automatic test_saturation();
        d0 = 4'b0110; d1 = 4'b1001; s = 1'b0;
        pulse_reset();
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
`ifdef MUX_2_SWITCH_CNT_EN
            if (n == 255 || n == 256 || n == 300) begin
                total_cnt++;
                if (sel_cnt !== ((n == 255) ? 8'd254 : 8'd255))
                    $display("FAIL sat_sel_cnt_edge%0d: got %0d, required %0d",
                             n, sel_cnt, (n == 255) ? 254 : 255);
                else pass_cnt++;
            end
`endif
            s = ~s;
        end
        // s was last sampled as 1 at edge 300, so y_q holds d1
        total_cnt++;
        if (y_q !== 4'b1001) $display("FAIL sat_y_q: got %b, required 1001", y_q);
        else pass_cnt++;
        s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef MUX_2_SWITCH_CNT_EN
        s = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (sel_cnt !== 8'd255) $display("FAIL sat_hold: got %0d, required 255", sel_cnt);
        else pass_cnt++;
`endif
    endtask

    // Bits 3 and 0 agree between d0 and d1 and must be 1 and 0; bits 2:1
    // differ and are X in a four-state simulator, so they are masked off.
    task automatic test_x_select();
        logic [WIDTH-1:0] agree;
        @(posedge clk);
        d0 = 4'b1100; d1 = 4'b1010; s = 1'bx;
        #1;
        agree = y & 4'b1001;
        total_cnt++;
        if (agree !== 4'b1000) $display("FAIL x_select_agree_bits: got %b, required 1xx0", y);
        else pass_cnt++;
        s = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vd0 [4] = '{4'h3, 4'h9, 4'hE, 4'h0};
        logic [WIDTH-1:0] vd1 [4] = '{4'hC, 4'h6, 4'h1, 4'hF};
        logic             vs  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [WIDTH-1:0] exp_y [4] = '{4'h3, 4'h6, 4'h1, 4'h0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                total_cnt++;
                if (y_q !== exp_y[i-1])
                    $display("FAIL b2b_y_q_%0d: got %b, required %b", i - 1, y_q, exp_y[i-1]);
                else pass_cnt++;
            end
            d0 = vd0[i]; d1 = vd1[i]; s = vs[i];
            #1;
            total_cnt++;
            if (y !== exp_y[i]) $display("FAIL b2b_y_%0d: got %b, required %b", i, y, exp_y[i]);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        total_cnt++;
        if (y_q !== exp_y[3]) $display("FAIL b2b_y_q_3: got %b, required %b", y_q, exp_y[3]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_select_0();
        test_select_1();
        test_toggle();
        test_async_reset();
        test_saturation();
        test_x_select();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
